// File: rtl/us_pkg.sv
// Shared HC-SR04 timing constants and state encoding, used by both the echo
// emulator and the measuring controller so the cm scaling agrees at both ends.
package us_pkg;

  typedef enum logic [2:0] {
    US_IDLE      = 3'd0,
    US_TRIG_HIGH = 3'd1,
    US_BURST     = 3'd2,
    US_ECHO      = 3'd3,
    US_HOLDOFF   = 3'd4
  } us_state_t;

  localparam int MIN_TRIG_CYC = 500;
  localparam int BURST_CYC    = 10000;
  localparam int CYC_PER_CM   = 2900;
  localparam int MAX_CM       = 400;
  localparam int TIMEOUT_CYC  = 1900000;
  localparam int HOLDOFF_CYC  = 500000;
  localparam int CNT_W        = 24;

endpackage

// File: rtl/us_echo_emulator_if.sv
// Sensor pin pair: trigger from the controller, echo back to it.
interface us_echo_emulator_if;
  logic trig_in;
  logic echo_out;

  modport master (output trig_in, input echo_out);
  modport slave  (input trig_in, output echo_out);
endinterface

// File: rtl/us_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with edge detects built from
// the synchronised level and its one-cycle-delayed copy.
module us_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/us_echo_emulator.sv
// HC-SR04 sensor-side model: qualifies the trigger width, waits out the burst,
// then returns an echo whose width encodes the latched distance.
module us_echo_emulator #(
  parameter int MIN_TRIG_CYC = us_pkg::MIN_TRIG_CYC,
  parameter int BURST_CYC    = us_pkg::BURST_CYC,
  parameter int CYC_PER_CM   = us_pkg::CYC_PER_CM,
  parameter int MAX_CM       = us_pkg::MAX_CM,
  parameter int TIMEOUT_CYC  = us_pkg::TIMEOUT_CYC,
  parameter int HOLDOFF_CYC  = us_pkg::HOLDOFF_CYC,
  parameter int CNT_W        = us_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  us_echo_emulator_if.slave   pins,
  input  logic [8:0]          distance_cm,
  output logic                busy,
  output logic                short_trig,
  output logic [15:0]         echo_count
);

  import us_pkg::*;

  localparam logic [2:0] S_IDLE      = US_IDLE;
  localparam logic [2:0] S_TRIG_HIGH = US_TRIG_HIGH;
  localparam logic [2:0] S_BURST     = US_BURST;
  localparam logic [2:0] S_ECHO      = US_ECHO;
  localparam logic [2:0] S_HOLDOFF   = US_HOLDOFF;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_TRIG_C   = CNT_W'(MIN_TRIG_CYC);
  localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYC - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYC);
  localparam logic [8:0]       MAX_CM_C     = 9'(MAX_CM);

  logic             trig_s;
  logic             trig_rise_s;
  logic             trig_fall_s;

  logic [2:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [8:0]       dist_q,   dist_d;
  logic [CNT_W-1:0] len_q,    len_d;
  logic             echo_q,   echo_d;
  logic             busy_q,   busy_d;
  logic             short_q,  short_d;
  logic [15:0]      count_q,  count_d;

  logic [20:0]      prod_s;
  logic [CNT_W-1:0] len_s;

  us_sync_edge u_trig_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pins.trig_in),
    .sync_o  (trig_s),
    .rise_o  (trig_rise_s),
    .fall_o  (trig_fall_s)
  );

  // Echo length from the latched distance; 0 cm and beyond-range both mean "no object"
  always_comb begin
    prod_s = 21'(dist_q) * 21'(CYC_PER_CM);
    if ((dist_q != 9'd0) && (dist_q <= MAX_CM_C)) begin
      len_s = CNT_W'(prod_s);
    end else begin
      len_s = TIMEOUT_C;
    end
  end

  // Next-state logic; every state reuses cnt as its own cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    len_d   = len_q;
    count_d = count_q;
    short_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_rise_s) begin
          state_d = S_TRIG_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIG_HIGH: begin
        if (trig_fall_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (cnt_q >= MIN_TRIG_C) begin
            dist_d  = distance_cm;
            state_d = S_BURST;
          end else begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end else if (trig_s && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_BURST: begin
        if (cnt_q == BURST_LAST) begin
          state_d = S_ECHO;
          cnt_d   = {CNT_W{1'b0}};
          len_d   = len_s;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ECHO: begin
        if (cnt_q == (len_q - CNT_ONE)) begin
          state_d = S_HOLDOFF;
          cnt_d   = {CNT_W{1'b0}};
          count_d = count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    echo_d = (state_d == S_ECHO);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears the pins without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      dist_q  <= 9'd0;
      len_q   <= {CNT_W{1'b0}};
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dist_q  <= dist_d;
      len_q   <= len_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      short_q <= short_d;
      count_q <= count_d;
    end
  end

  assign pins.echo_out = echo_q;
  assign busy          = busy_q;
  assign short_trig    = short_q;
  assign echo_count    = count_q;

endmodule

// File: tb/tb_us_echo_emulator.sv
// Directed bench for us_echo_emulator with shortened timing constants.
module tb_us_echo_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  distance_cm;
  logic        busy;
  logic        short_trig;
  logic [15:0] echo_count;

  int tests_run    = 0;
  int tests_failed = 0;

  us_echo_emulator_if pins ();

  us_echo_emulator #(
    .MIN_TRIG_CYC (5),
    .BURST_CYC    (10),
    .CYC_PER_CM   (3),
    .TIMEOUT_CYC  (2000),
    .HOLDOFF_CYC  (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pins        (pins),
    .distance_cm (distance_cm),
    .busy        (busy),
    .short_trig  (short_trig),
    .echo_count  (echo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig(input int n);
    pins.trig_in = 1'b1;
    repeat (n) tick();
    pins.trig_in = 1'b0;
  endtask

  task automatic wait_rise(output int d);
    d = -1;
    for (int i = 1; i <= 4000; i++) begin
      tick();
      if (pins.echo_out === 1'b1) begin
        d = i;
        break;
      end
    end
  endtask

  task automatic wait_fall(output int w);
    w = -1;
    for (int i = 1; i <= 4000; i++) begin
      tick();
      if (pins.echo_out === 1'b0) begin
        w = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int h);
    h = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (busy === 1'b0) begin
        h = i;
        break;
      end
    end
  endtask

  // Rise delay from trigger release: 2 sync cycles + 1 to sample low (T0) + BURST_CYC
  localparam int RISE_DLY = 13;

  task automatic test_reset();
    rst_n        = 1'b0;
    pins.trig_in = 1'b0;
    distance_cm  = 9'd0;
    repeat (3) tick();
    tests_run++;
    if ({pins.echo_out, busy, short_trig, echo_count} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b/%b/%b/%0d expected all zero", pins.echo_out, busy, short_trig, echo_count);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({pins.echo_out, busy, short_trig, echo_count} !== 19'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b/%b/%b/%0d expected all zero", pins.echo_out, busy, short_trig, echo_count);
    end
  endtask

  task automatic test_normal();
    int d, w, h;
    distance_cm = 9'd10;
    pulse_trig(6);
    wait_rise(d);
    tests_run++;
    if (d !== RISE_DLY) begin
      tests_failed++;
      $display("FAIL normal_rise: got %0d expected %0d", d, RISE_DLY);
    end
    wait_fall(w);
    tests_run++;
    if (w !== 30) begin
      tests_failed++;
      $display("FAIL normal_width: got %0d expected 30", w);
    end
    tests_run++;
    if (echo_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL normal_count: got %0d expected 1", echo_count);
    end
    wait_idle(h);
    tests_run++;
    if (h !== 20) begin
      tests_failed++;
      $display("FAIL normal_holdoff: got %0d expected 20", h);
    end
  endtask

  task automatic test_short_trig();
    int pulses, echo_hi;
    pulses  = 0;
    echo_hi = 0;
    distance_cm = 9'd10;
    pulse_trig(3);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (short_trig === 1'b1) pulses++;
      if (pins.echo_out === 1'b1) echo_hi++;
    end
    tests_run++;
    if (pulses !== 1) begin
      tests_failed++;
      $display("FAIL short_pulse_count: got %0d expected 1", pulses);
    end
    tests_run++;
    if (echo_hi !== 0) begin
      tests_failed++;
      $display("FAIL short_no_echo: got %0d echo cycles expected 0", echo_hi);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (echo_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL short_count: got %0d expected 1", echo_count);
    end
  endtask

  task automatic test_range();
    int d, w, h;
    logic [8:0] dist_tab [4] = '{9'd0, 9'd401, 9'd400, 9'd1};
    int         trig_tab [4] = '{6, 6, 6, 5};
    int         wid_tab  [4] = '{2000, 2000, 1200, 3};
    for (int k = 0; k < 4; k++) begin
      distance_cm = dist_tab[k];
      pulse_trig(trig_tab[k]);
      wait_rise(d);
      tests_run++;
      if (d !== RISE_DLY) begin
        tests_failed++;
        $display("FAIL range_rise[%0d]: got %0d expected %0d", dist_tab[k], d, RISE_DLY);
      end
      wait_fall(w);
      tests_run++;
      if (w !== wid_tab[k]) begin
        tests_failed++;
        $display("FAIL range_width[%0d]: got %0d expected %0d", dist_tab[k], w, wid_tab[k]);
      end
      wait_idle(h);
    end
    tests_run++;
    if (echo_count !== 16'd5) begin
      tests_failed++;
      $display("FAIL range_count: got %0d expected 5", echo_count);
    end
  endtask

  task automatic test_retrigger();
    int d, w, h, rose;
    distance_cm = 9'd10;
    pulse_trig(6);
    wait_rise(d);
    w = -1;
    for (int k = 1; k <= 100; k++) begin
      pins.trig_in = (k >= 5 && k < 11);
      tick();
      if (pins.echo_out === 1'b0) begin
        w = k;
        break;
      end
    end
    pins.trig_in = 1'b0;
    tests_run++;
    if (w !== 30) begin
      tests_failed++;
      $display("FAIL retrig_echo_width: got %0d expected 30", w);
    end
    h    = -1;
    rose = 0;
    for (int k = 1; k <= 100; k++) begin
      pins.trig_in = (k >= 3 && k < 9);
      tick();
      if (pins.echo_out === 1'b1) rose++;
      if (busy === 1'b0) begin
        h = k;
        break;
      end
    end
    pins.trig_in = 1'b0;
    tests_run++;
    if (h !== 20 || rose !== 0) begin
      tests_failed++;
      $display("FAIL retrig_holdoff: got len %0d echo %0d expected len 20 echo 0", h, rose);
    end
    tests_run++;
    if (echo_count !== 16'd6) begin
      tests_failed++;
      $display("FAIL retrig_count: got %0d expected 6", echo_count);
    end
    pulse_trig(6);
    wait_rise(d);
    wait_fall(w);
    tests_run++;
    if (d !== RISE_DLY || w !== 30) begin
      tests_failed++;
      $display("FAIL retrig_second_echo: got rise %0d width %0d expected %0d/30", d, w, RISE_DLY);
    end
    tests_run++;
    if (echo_count !== 16'd7) begin
      tests_failed++;
      $display("FAIL retrig_second_count: got %0d expected 7", echo_count);
    end
    wait_idle(h);
  endtask

  task automatic test_distance_latch();
    int d, w, h;
    distance_cm = 9'd10;
    pulse_trig(6);
    repeat (5) tick();
    distance_cm = 9'd50;
    wait_rise(d);
    tests_run++;
    if (d !== RISE_DLY - 5) begin
      tests_failed++;
      $display("FAIL latch_rise: got %0d expected %0d", d, RISE_DLY - 5);
    end
    wait_fall(w);
    tests_run++;
    if (w !== 30) begin
      tests_failed++;
      $display("FAIL latch_width: got %0d expected 30", w);
    end
    wait_idle(h);
  endtask

  task automatic test_reset_in_echo();
    int d, w, h;
    distance_cm = 9'd10;
    pulse_trig(6);
    wait_rise(d);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (pins.echo_out !== 1'b0 || busy !== 1'b0 || echo_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got echo %b busy %b count %0d expected 0/0/0", pins.echo_out, busy, echo_count);
    end
    repeat (5) tick();
    rst_n       = 1'b1;
    distance_cm = 9'd2;
    tick();
    pulse_trig(6);
    wait_rise(d);
    tests_run++;
    if (d !== RISE_DLY) begin
      tests_failed++;
      $display("FAIL after_reset_rise: got %0d expected %0d", d, RISE_DLY);
    end
    wait_fall(w);
    tests_run++;
    if (w !== 6) begin
      tests_failed++;
      $display("FAIL after_reset_width: got %0d expected 6", w);
    end
    tests_run++;
    if (echo_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL after_reset_count: got %0d expected 1", echo_count);
    end
    wait_idle(h);
    tests_run++;
    if (h !== 20) begin
      tests_failed++;
      $display("FAIL after_reset_holdoff: got %0d expected 20", h);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short_trig();
    test_range();
    test_retrigger();
    test_distance_latch();
    test_reset_in_echo();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
